ts_sync_recovery: RTL and testbench

//  Per-stream MPEG-2 TS packet aligner. It sits between one input CDC FIFO read port and the

---
 rtl/ts_pkg.sv | 14 +
 rtl/ts_sync_recovery.sv | 142 ++++++++++++++
 tb/tb_ts_sync_recovery.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ts_pkg.sv
// Shared definitions for the transport-stream sync recovery blocks:
// default packet geometry and the aligner state encoding.
package ts_pkg;

  localparam int          TS_PKT_LEN   = 188;
  localparam logic [7:0]  TS_SYNC_BYTE = 8'h47;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCK   = 2'd2
  } ts_state_e;

endpackage

// File: rtl/ts_sync_recovery.sv
// Per-stream MPEG-2 TS packet aligner: hunts for the sync byte, confirms it at
// packet spacing, then forwards an aligned byte stream with a per-packet sync pulse.
module ts_sync_recovery
  import ts_pkg::*;
#(
  parameter int         PKT_LEN    = TS_PKT_LEN,
  parameter logic [7:0] SYNC_BYTE  = TS_SYNC_BYTE,
  parameter int         LOCK_CNT   = 3,
  parameter int         UNLOCK_CNT = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] byte_in,
  input  logic       valid_in,
  output logic [7:0] byte_out,
  output logic       valid_out,
  output logic       sync_out,
  output logic       locked,
  output logic       sync_loss
);

  localparam int PW = $clog2(PKT_LEN);
  localparam int HW = $clog2(LOCK_CNT + 1);
  localparam int MW = $clog2(UNLOCK_CNT + 1);

  localparam logic [PW-1:0] POS_LAST   = PW'(PKT_LEN - 1);
  localparam logic [HW-1:0] HITS_LOCK  = HW'(LOCK_CNT);
  localparam logic [HW-1:0] HITS_PRE   = HW'(LOCK_CNT - 1);
  localparam logic [MW-1:0] MISS_PRE   = MW'(UNLOCK_CNT - 1);

  ts_state_e     state_reg, state_next;
  logic [PW-1:0] pos_reg, pos_next, pos_inc;
  logic [HW-1:0] hits_reg, hits_next;
  logic [MW-1:0] miss_reg, miss_next;
  logic          fwd, sync_hit, loss;
  logic          at_zero, is_sync;

  assign at_zero = (pos_reg == '0);
  assign is_sync = (byte_in == SYNC_BYTE);
  assign pos_inc = (pos_reg == POS_LAST) ? '0 : pos_reg + PW'(1);

  always_comb begin
    state_next = state_reg;
    pos_next   = pos_reg;
    hits_next  = hits_reg;
    miss_next  = miss_reg;
    fwd        = 1'b0;
    sync_hit   = 1'b0;
    loss       = 1'b0;
    if (valid_in) begin
      unique case (state_reg)
        HUNT: begin
          if (is_sync) begin
            state_next = VERIFY;
            hits_next  = HW'(1);
            pos_next   = PW'(1);
          end
        end
        VERIFY: begin
          pos_next = pos_inc;
          if (at_zero) begin
            if (is_sync) begin
              if (hits_reg >= HITS_PRE) begin
                state_next = LOCK;
                hits_next  = HITS_LOCK;
                miss_next  = '0;
                fwd        = 1'b1;
                sync_hit   = 1'b1;
              end else begin
                hits_next = hits_reg + HW'(1);
              end
            end else begin
              // The failing byte is consumed; hunting resumes with the next byte.
              state_next = HUNT;
              hits_next  = '0;
              pos_next   = '0;
            end
          end
        end
        LOCK: begin
          pos_next = pos_inc;
          fwd      = 1'b1;
          if (at_zero) begin
            if (is_sync) begin
              sync_hit  = 1'b1;
              miss_next = '0;
            end else if (miss_reg >= MISS_PRE) begin
              state_next = HUNT;
              pos_next   = '0;
              hits_next  = '0;
              miss_next  = '0;
              fwd        = 1'b0;
              loss       = 1'b1;
            end else begin
              miss_next = miss_reg + MW'(1);
            end
          end
        end
        default: begin
          state_next = HUNT;
          pos_next   = '0;
          hits_next  = '0;
          miss_next  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= HUNT;
      pos_reg   <= '0;
      hits_reg  <= '0;
      miss_reg  <= '0;
    end else begin
      state_reg <= state_next;
      pos_reg   <= pos_next;
      hits_reg  <= hits_next;
      miss_reg  <= miss_next;
    end
  end

  // byte_out only updates on forwarded bytes so it holds across gaps and drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_out  <= 8'h00;
      valid_out <= 1'b0;
      sync_out  <= 1'b0;
      locked    <= 1'b0;
      sync_loss <= 1'b0;
    end else begin
      valid_out <= fwd;
      sync_out  <= sync_hit;
      sync_loss <= loss;
      locked    <= (state_next == LOCK);
      if (fwd) begin
        byte_out <= byte_in;
      end
    end
  end

endmodule

// File: tb/tb_ts_sync_recovery.sv
// Scoreboard bench for ts_sync_recovery: the driver predicts each cycle's outputs into
// a queue, a monitor pops and compares, and event positions are checked against hand values.
module tb_ts_sync_recovery;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] byte_in;
  logic       valid_in;
  logic [7:0] byte_out;
  logic       valid_out, sync_out, locked, sync_loss;

  ts_sync_recovery dut (
    .clk(clk), .rst_n(rst_n), .byte_in(byte_in), .valid_in(valid_in),
    .byte_out(byte_out), .valid_out(valid_out), .sync_out(sync_out),
    .locked(locked), .sync_loss(sync_loss)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       v;
    logic       s;
    logic       l;
    logic       k;
    logic [7:0] b;
  } out_t;

  typedef struct {
    out_t exp;
    int   idx;
  } sb_t;

  sb_t exp_q[$];
  int  sync_log[$];
  int  loss_log[$];
  int  n_cmp = 0;
  int  n_bad = 0;
  int  t_idx;

  // Reference model state
  int         m_state, m_pos, m_hits, m_miss;
  logic [7:0] m_byte;

  task automatic model_reset();
    m_state = 0; m_pos = 0; m_hits = 0; m_miss = 0; m_byte = 8'h00;
  endtask

  task automatic model_step(input bit v, input logic [7:0] b, output out_t e);
    bit at0, sy;
    e = '0;
    if (v) begin
      at0 = (m_pos == 0);
      sy  = (b == 8'h47);
      case (m_state)
        0: if (sy) begin m_state = 1; m_hits = 1; m_pos = 1; end
        1: begin
          if (at0 && !sy) begin
            m_state = 0; m_hits = 0; m_pos = 0;
          end else begin
            if (at0) begin
              m_hits = (m_hits + 1 > 3) ? 3 : m_hits + 1;
              if (m_hits == 3) begin
                m_state = 2; m_miss = 0; e.v = 1; e.s = 1; m_byte = b;
              end
            end
            m_pos = (m_pos + 1) % 188;
          end
        end
        default: begin
          if (at0 && !sy && (m_miss + 1 >= 3)) begin
            m_state = 0; m_pos = 0; m_hits = 0; m_miss = 0; e.l = 1;
          end else begin
            e.v = 1; e.s = at0 && sy; m_byte = b;
            if (at0) m_miss = sy ? 0 : m_miss + 1;
            m_pos = (m_pos + 1) % 188;
          end
        end
      endcase
    end
    e.k = (m_state == 2);
    e.b = m_byte;
  endtask

  task automatic send(input logic [7:0] b, input bit v);
    sb_t  s;
    out_t e;
    @(negedge clk);
    byte_in  = b;
    valid_in = v;
    model_step(v, b, e);
    s.exp = e;
    s.idx = v ? t_idx : -1;
    if (v) t_idx++;
    exp_q.push_back(s);
  endtask

  // One packet: given byte 0, payload (i-1)&0x3F never contains 0x47.
  // With gaps, an invalid 0x47 follows every byte and must be ignored.
  task automatic pkt(input logic [7:0] first, input bit gaps, input int nbytes = 188);
    logic [7:0] b;
    for (int i = 0; i < nbytes; i++) begin
      b = (i == 0) ? first : 8'((i - 1) & 63);
      send(b, 1'b1);
      if (gaps) send(8'h47, 1'b0);
    end
  endtask

  task automatic drain();
    send(8'h00, 1'b0);
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: queue depth %0d, required 0", exp_q.size());
    end
  endtask

  task automatic start_test();
    t_idx = 0;
    sync_log.delete();
    loss_log.delete();
  endtask

  task automatic check_log(input string nm, input bit use_loss, input int n, input int e0, input int e1);
    int got[$];
    got = use_loss ? loss_log : sync_log;
    n_cmp++;
    if (got.size() != n) begin
      n_bad++;
      $display("FAIL %s count: got %0d events, required %0d", nm, got.size(), n);
    end else begin
      for (int i = 0; i < n; i++) begin
        n_cmp++;
        if (got[i] != ((i == 0) ? e0 : e1)) begin
          n_bad++;
          $display("FAIL %s[%0d]: got byte index %0d, required %0d", nm, i, got[i], (i == 0) ? e0 : e1);
        end
      end
    end
  endtask

  task automatic check_idle(input string nm, input bit exp_locked);
    out_t a;
    a = {valid_out, sync_out, sync_loss, locked, byte_out};
    n_cmp++;
    if (a.v || a.s || a.l || (a.k != exp_locked) || (!exp_locked && a.b != 8'h00)) begin
      n_bad++;
      $display("FAIL %s: got v=%0b s=%0b l=%0b k=%0b b=%02h, required zeros with locked=%0b",
               nm, a.v, a.s, a.l, a.k, a.b, exp_locked);
    end
  endtask

  // Monitor: one expectation per cycle, sampled 1 time unit after the edge.
  initial begin
    sb_t  s;
    out_t a;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        s = exp_q.pop_front();
        a = {valid_out, sync_out, sync_loss, locked, byte_out};
        n_cmp++;
        if (a != s.exp) begin
          n_bad++;
          $display("FAIL cycle idx=%0d: got v=%0b s=%0b l=%0b k=%0b b=%02h, required v=%0b s=%0b l=%0b k=%0b b=%02h",
                   s.idx, a.v, a.s, a.l, a.k, a.b, s.exp.v, s.exp.s, s.exp.l, s.exp.k, s.exp.b);
        end
        if (sync_out) sync_log.push_back(s.idx);
        if (sync_loss) loss_log.push_back(s.idx);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; byte_in = 8'h00; valid_in = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_idle("reset_state", 1'b0);
    rst_n = 1'b1;

    // 1: clean continuous stream locks on the third sync
    start_test();
    repeat (4) pkt(8'h47, 1'b0);
    drain();
    check_log("t1_sync", 1'b0, 2, 376, 564);
    $display("t1 clean stream: sync at valid bytes 376/564 checked");

    // 2: one missing sync is forwarded and tolerated
    start_test();
    pkt(8'h00, 1'b0);
    pkt(8'h47, 1'b0);
    drain();
    check_log("t2_sync", 1'b0, 1, 188, 0);
    check_idle("t2_locked", 1'b1);
    $display("t2 single bad sync: lock kept");

    // 3: three missing syncs drop lock, relock after three good syncs
    start_test();
    repeat (3) pkt(8'h00, 1'b0);
    repeat (4) pkt(8'h47, 1'b0);
    drain();
    check_log("t3_loss", 1'b1, 1, 376, 0);
    check_log("t3_sync", 1'b0, 2, 940, 1128);
    $display("t3 lock loss at byte 376, relock at 940");

    // 6: asynchronous reset mid-packet while locked
    start_test();
    pkt(8'h47, 1'b0, 100);
    drain();
    #1 rst_n = 1'b0;
    #1 check_idle("t6_async_reset", 1'b0);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    start_test();
    repeat (4) pkt(8'h47, 1'b0);
    drain();
    check_log("t6_sync", 1'b0, 2, 376, 564);
    $display("t6 reset mid-packet, relock at 376");

    // 4: false 0x47 at offset 10 ahead of the true alignment at offset 20
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    start_test();
    for (int i = 0; i < 20; i++) send((i == 10) ? 8'h47 : 8'(8'h80 + i), 1'b1);
    repeat (4) pkt(8'h47, 1'b0);
    drain();
    check_log("t4_sync", 1'b0, 1, 584, 0);
    $display("t4 false sync rejected, lock at 584");

    // 5: alternating valid gaps, counted in valid bytes only
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    start_test();
    repeat (4) pkt(8'h47, 1'b1);
    drain();
    check_log("t5_sync", 1'b0, 2, 376, 564);
    $display("t5 gapped stream: sync at valid bytes 376/564 checked");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
